// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator and the fixed-point stages
// downstream of it: default widths and the accumulator state encoding.
package mac_pkg;

    localparam int DEF_DATA_W    = 16;  // operand / result width
    localparam int DEF_FRAC_BITS = 8;   // Q8.8 by default
    localparam int DEF_ACC_W     = 40;  // >= 2*DATA_W + LEN_W
    localparam int DEF_LEN_W     = 8;   // vector-length field width

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } mac_state_t;

endpackage

// File: rtl/mac_round_sat.sv
// Combinational round-half-up and saturate from a wide signed sum down to a
// DATA_W signed result with FRAC_BITS fractional bits preserved.
// Ports:
//   sum_i  : ACC_W-bit signed sum (2*FRAC_BITS fractional bits)
//   data_o : DATA_W-bit rounded, clamped result
//   ovf_o  : 1 when the rounded value was clamped
module mac_round_sat
    import mac_pkg::*;
#(
    parameter int ACC_W     = DEF_ACC_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic signed [ACC_W-1:0]  sum_i,
    output logic        [DATA_W-1:0] data_o,
    output logic                     ovf_o
);

    localparam logic signed [ACC_W:0] ONE   = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] HALF  = ONE <<< (FRAC_BITS - 1);
    localparam logic signed [ACC_W:0] MAX_V = (ONE <<< (DATA_W - 1)) - ONE;
    localparam logic signed [ACC_W:0] MIN_V = -(ONE <<< (DATA_W - 1));

    logic signed [ACC_W:0] sum_ext;
    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;

    // One guard bit so adding the half-LSB can never wrap.
    assign sum_ext = {sum_i[ACC_W-1], sum_i};
    assign biased  = sum_ext + HALF;
    // Arithmetic shift floors, so exact halves round toward +inf.
    assign shifted = biased >>> FRAC_BITS;

    always_comb begin
        data_o = shifted[DATA_W-1:0];
        ovf_o  = 1'b0;
        if (shifted > MAX_V) begin
            data_o = MAX_V[DATA_W-1:0];
            ovf_o  = 1'b1;
        end else if (shifted < MIN_V) begin
            data_o = MIN_V[DATA_W-1:0];
            ovf_o  = 1'b1;
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// Dot-product accumulator: multiplies streamed signed Q-format operand pairs,
// accumulates cfg_len products, then rounds/saturates the sum to DATA_W bits
// and holds it behind a valid/ready handshake.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   cfg_len            : products per vector, sampled on first beat (0 -> 1)
//   in_valid/in_ready  : operand-pair handshake (in_ready low while holding)
//   in_a, in_b         : signed operands
//   out_valid/out_ready: result handshake
//   out_data, out_ovf  : rounded result and clamp flag
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int LEN_W     = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf
);

    mac_state_t               state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic                     out_ovf_q, out_ovf_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_sum;
    logic [LEN_W-1:0]           len_eff;
    logic [LEN_W-1:0]           cnt_inc;
    logic                       beat;
    logic [DATA_W-1:0]          rs_data;
    logic                       rs_ovf;

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    assign beat     = in_valid && in_ready;
    assign prod     = $signed(in_a) * $signed(in_b);
    assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign len_eff  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    assign cnt_inc  = cnt_q + LEN_W'(1);

    // Candidate next sum, computed outside the FSM process so the rounding
    // path does not loop back through the same always_comb block.
    assign acc_sum = (state_q == IDLE) ? prod_ext : (acc_q + prod_ext);

    mac_round_sat #(
        .ACC_W     (ACC_W),
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_sat (
        .sum_i  (acc_sum),
        .data_o (rs_data),
        .ovf_o  (rs_ovf)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    acc_d = acc_sum;
                    cnt_d = LEN_W'(1);
                    len_d = len_eff;
                    if (len_eff == LEN_W'(1)) begin
                        state_d    = HOLD;
                        out_data_d = rs_data;
                        out_ovf_d  = rs_ovf;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d    = HOLD;
                        out_data_d = rs_data;
                        out_ovf_d  = rs_ovf;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Dot-product accumulator that sits directly upstream of the activation unit. It multiplies streamed signed Q-format operand pairs and accumulates them in a wide register. At the end of each vector it rounds and saturates the sum to 16 bits and presents it with a valid/ready handshake. `out_valid`/`out_data` drive the activation unit's `start`/`buffer` (with `out_ready` tied high), or an intermediate buffer.

## Interface
Parameters:
- `DATA_W`, 16: operand and result width (signed two's complement).
- `FRAC_BITS`, 8: fractional bits of operands and result (Q8.8 by default); range 1..DATA_W-1.
- `ACC_W`, 40: accumulator width; must satisfy ACC_W ≥ 2·DATA_W + LEN_W.
- `LEN_W`, 8: width of the vector-length field.

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `cfg_len` in LEN_W: products per vector; sampled on the first accepted beat of each vector; 0 treated as 1.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: accumulator can accept a pair.
- `in_a`, `in_b` in DATA_W: signed operands.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_data` out DATA_W: rounded, saturated result.
- `out_ovf` out 1: result was clamped; valid with `out_valid`.

## Operation
- States: IDLE, ACCUM, HOLD.
- `in_ready` = 1 in IDLE and ACCUM; 0 in HOLD.
- Beat = `in_valid && in_ready`.
- Product p = signed(in_a)·signed(in_b), 2·DATA_W bits, sign-extended to ACC_W.
- IDLE + beat:
  - acc ← p; cnt ← 1; len ← max(cfg_len, 1).
  - If len = 1, go to HOLD; else go to ACCUM.
- ACCUM + beat: acc ← acc + p; cnt ← cnt + 1. If cnt + 1 = len, go to HOLD.
- Cycles without a beat leave acc and cnt unchanged (bubbles allowed anywhere).
- Finalization, on the transition into HOLD, using the final sum s (acc_next):
  - r = (s + 2^(FRAC_BITS−1)) >>> FRAC_BITS, arithmetic shift, so halves round toward +∞.
  - Clamp r to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - `out_ovf` = 1 iff clamped.
  - `out_data`, `out_ovf` registered; `out_valid` ← 1.
- HOLD: `out_valid` = 1; `out_data` and `out_ovf` stable. On `out_ready`, `out_valid` ← 0 and go to IDLE.
- `cfg_len` changes mid-vector are ignored.
- Accumulator cannot overflow within spec (ACC_W constraint).

## Timing
- Reset values: state IDLE, acc 0, cnt 0, `out_valid` 0, `out_data` 0, `out_ovf` 0, `in_ready` 1 the cycle after reset release.
- Reset asserted mid-vector or in HOLD discards the partial sum or pending result; no output is produced.
- Latency: last beat accepted at edge t → `out_valid` = 1 after edge t (visible in cycle t+1).
- Minimum per vector: len beats + 1 HOLD cycle.
- The next vector's first beat is accepted no earlier than the cycle after the result handshake, since `in_ready` = 0 in HOLD.
- The multiply-add path is single-cycle combinational into acc; no internal pipeline.
- Backpressure: `out_valid` never drops without `out_ready`; `out_data` does not change while `out_valid && !out_ready`.

## Structure
- Shared package `mac_pkg`: DATA_W, FRAC_BITS, ACC_W, LEN_W defaults; state enum `mac_state_t` {IDLE, ACCUM, HOLD}.
- Sub-module `mac_round_sat`: combinational; takes ACC_W-bit sum and FRAC_BITS, returns DATA_W result plus ovf flag. Reused by later fixed-point stages.

## Test plan
- L=1, a=0x0100, b=0x0200 → out_data 0x0200, ovf 0, `out_valid` one cycle after the beat.
- L=3, pairs (0x0100,0x0100), (0xFF00,0x0300), (0x0080,0x0200) → 1 − 3 + 1 = −1.0 → 0xFF00, ovf 0; insert 2 idle cycles between beats, result unchanged.
- Rounding: L=1 (0x0001,0x0080) → 0x0001; L=1 (0xFFFF,0x0080) → 0x0000; L=1 (0xFFFF,0x0081) → 0xFFFF.
- Saturation: L=4, all pairs (0x7FFF,0x7FFF) → 0x7FFF, ovf 1. L=2, pairs (0x8000,0x7FFF) → 0x8000, ovf 1.
- Backpressure: `out_ready` = 0 for 5 cycles → `out_valid`, `out_data` stable, `in_ready` = 0 throughout; on release, one handshake, then `in_ready` = 1.
- cfg_len=0 → each beat yields one result. Reset pulse after 2 of 4 beats → no output. Next vector L=1 (0x0100,0x0100) → 0x0100.
